vdp_vram_arb: RTL and testbench



---
 rtl/vdp_pkg.sv | 14 +
 rtl/vdp_vram_rd_return.sv | 57 +++++
 rtl/vdp_vram_arb.sv | 131 +++++++++++++
 tb/tb_vdp_vram_arb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared VDP types: VRAM read-owner tag and default VRAM size
package vdp_pkg;

  localparam int VRAM_SIZE_DEFAULT = 8192;

  // Who issued the read currently in flight through the VRAM port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GFX  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_SPR  = 2'd3
  } own_tag_t;

endpackage

// File: rtl/vdp_vram_rd_return.sv
// rtl/vdp_vram_rd_return.sv - read-owner tag and read data return; sprite side under VDP_ARB_SPR_EN
module vdp_vram_rd_return
  import vdp_pkg::*;
(
  input  logic       pxclk,
  input  logic       reset_n,
  input  logic [1:0] rd_owner,
  input  logic [7:0] vram_dout,
  output logic       cpu_rd_valid,
  output logic [7:0] cpu_rdata,
  output logic       spr_rd_valid,
  output logic [7:0] spr_rdata
);

  own_tag_t tag;

  // Remember who owns the read granted this cycle; its data appears on vram_dout next cycle
  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      tag <= OWN_NONE;
    end else begin
      tag <= own_tag_t'(rd_owner);
    end
  end

  // Capture CPU read data and pulse its valid together with the capture
  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      cpu_rd_valid <= 1'b0;
      cpu_rdata    <= 8'h00;
    end else begin
      cpu_rd_valid <= (tag == OWN_CPU);
      if (tag == OWN_CPU) begin
        cpu_rdata <= vram_dout;
      end
    end
  end

`ifdef VDP_ARB_SPR_EN
  // Capture sprite read data and pulse its valid together with the capture
  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      spr_rd_valid <= 1'b0;
      spr_rdata    <= 8'h00;
    end else begin
      spr_rd_valid <= (tag == OWN_SPR);
      if (tag == OWN_SPR) begin
        spr_rdata <= vram_dout;
      end
    end
  end
`else
  assign spr_rd_valid = 1'b0;
  assign spr_rdata    = 8'h00;
`endif

endmodule

// File: rtl/vdp_vram_arb.sv
// rtl/vdp_vram_arb.sv - single-port VRAM arbiter gfx/cpu/sprite; sprite port enabled by VDP_ARB_SPR_EN
module vdp_vram_arb
  import vdp_pkg::*;
#(
  parameter int VRAM_SIZE       = VRAM_SIZE_DEFAULT,
  parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE),
  parameter int SPR_MAX_WAIT    = 4
) (
  input  logic                       pxclk,
  input  logic                       reset_n,
  input  logic [VRAM_ADDR_WIDTH-1:0] gfx_addr,
  input  logic                       gfx_rd_tick,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                 cpu_wdata,
  output logic                       cpu_busy,
  output logic                       cpu_rd_valid,
  output logic [7:0]                 cpu_rdata,
  input  logic                       spr_rd_req,
  input  logic [VRAM_ADDR_WIDTH-1:0] spr_addr,
  output logic                       spr_rd_ack,
  output logic                       spr_rd_valid,
  output logic [7:0]                 spr_rdata,
  output logic                       vram_en,
  output logic                       vram_we,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]                 vram_din,
  input  logic [7:0]                 vram_dout
);

  logic                       cpu_pend_we;
  logic [VRAM_ADDR_WIDTH-1:0] cpu_pend_addr;
  logic [7:0]                 cpu_pend_wdata;
  logic                       gnt_cpu;
  own_tag_t                   rd_owner;

`ifdef VDP_ARB_SPR_EN
  localparam int WAIT_W = $clog2(SPR_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SPR_MAX_WAIT);

  logic [WAIT_W-1:0] spr_wait;
  logic              spr_starved;
  logic              gnt_spr;

  assign spr_starved = spr_rd_req && (spr_wait == WAIT_MAX);

  // Gfx always wins; a starved sprite jumps ahead of the CPU
  always_comb begin
    gnt_spr = !gfx_rd_tick && spr_rd_req && (spr_starved || !cpu_busy);
    gnt_cpu = !gfx_rd_tick && cpu_busy && !spr_starved;
  end

  assign spr_rd_ack = gnt_spr;

  // Count consecutive lost sprite cycles, saturating; any ack or dropped request restarts it
  always_ff @(posedge pxclk) begin
    if (!reset_n || !spr_rd_req || gnt_spr) begin
      spr_wait <= '0;
    end else if (spr_wait != WAIT_MAX) begin
      spr_wait <= spr_wait + 1'b1;
    end
  end
`else
  logic unused_spr;
  assign unused_spr = &{1'b0, spr_rd_req, spr_addr};

  // Fixed order gfx > cpu when the sprite port is compiled out
  always_comb begin
    gnt_cpu = !gfx_rd_tick && cpu_busy;
  end

  assign spr_rd_ack = 1'b0;
`endif

  // Single-entry CPU request holder; requests arriving while it is full are dropped
  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      cpu_busy       <= 1'b0;
      cpu_pend_we    <= 1'b0;
      cpu_pend_addr  <= '0;
      cpu_pend_wdata <= 8'h00;
    end else if (gnt_cpu) begin
      cpu_busy <= 1'b0;
    end else if (cpu_req && !cpu_busy) begin
      cpu_busy       <= 1'b1;
      cpu_pend_we    <= cpu_we;
      cpu_pend_addr  <= cpu_addr;
      cpu_pend_wdata <= cpu_wdata;
    end
  end

  // Steer the VRAM port to the granted owner and tag reads for the return path
  always_comb begin
    vram_en   = 1'b0;
    vram_we   = 1'b0;
    vram_addr = '0;
    vram_din  = 8'h00;
    rd_owner  = OWN_NONE;
    if (gfx_rd_tick) begin
      vram_en   = 1'b1;
      vram_addr = gfx_addr;
      rd_owner  = OWN_GFX;
    end else if (gnt_cpu) begin
      vram_en   = 1'b1;
      vram_we   = cpu_pend_we;
      vram_addr = cpu_pend_addr;
      vram_din  = cpu_pend_we ? cpu_pend_wdata : 8'h00;
      rd_owner  = cpu_pend_we ? OWN_NONE : OWN_CPU;
    end
`ifdef VDP_ARB_SPR_EN
    else if (gnt_spr) begin
      vram_en   = 1'b1;
      vram_addr = spr_addr;
      rd_owner  = OWN_SPR;
    end
`endif
  end

  vdp_vram_rd_return u_rd_return (
    .pxclk        (pxclk),
    .reset_n      (reset_n),
    .rd_owner     (rd_owner),
    .vram_dout    (vram_dout),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rdata    (cpu_rdata),
    .spr_rd_valid (spr_rd_valid),
    .spr_rdata    (spr_rdata)
  );

endmodule

// File: tb/tb_vdp_vram_arb.sv
// tb/tb_vdp_vram_arb.sv - randomized bench for vdp_vram_arb against a cycle-level reference model
`timescale 1ns/1ps
module tb_vdp_vram_arb;

  localparam int AW   = 13;
  localparam int MAXW = 4;
`ifdef VDP_ARB_SPR_EN
  localparam bit SPR_EN = 1'b1;
`else
  localparam bit SPR_EN = 1'b0;
`endif

  logic          pxclk = 1'b0;
  logic          reset_n, gfx_rd_tick, cpu_req, cpu_we, spr_rd_req;
  logic [AW-1:0] gfx_addr, cpu_addr, spr_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_busy, cpu_rd_valid, spr_rd_ack, spr_rd_valid;
  logic [7:0]    cpu_rdata, spr_rdata;
  logic          vram_en, vram_we;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_din, vram_dout;

  always #20 pxclk = ~pxclk;

  vdp_vram_arb #(.VRAM_SIZE(8192), .SPR_MAX_WAIT(MAXW)) dut (
    .pxclk(pxclk), .reset_n(reset_n),
    .gfx_addr(gfx_addr), .gfx_rd_tick(gfx_rd_tick),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rd_valid(cpu_rd_valid), .cpu_rdata(cpu_rdata),
    .spr_rd_req(spr_rd_req), .spr_addr(spr_addr), .spr_rd_ack(spr_rd_ack),
    .spr_rd_valid(spr_rd_valid), .spr_rdata(spr_rdata),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
    .vram_dout(vram_dout)
  );

  // VRAM storage (written by the bench from sampled port values) and its read port
  logic [7:0] mem [0:8191];
  always @(posedge pxclk) if (vram_en && !vram_we) vram_dout <= mem[vram_addr];

  // Reference model state
  logic [7:0] exp_mem [0:8191];
  typedef struct { int due; bit spr; logic [7:0] data; } ret_t;
  ret_t       rq[$];
  int         cyc, m_wait, spr_lost, checks, failures;
  bit         m_busy, m_we, m_spr_acked;
  logic [AW-1:0] m_addr;
  logic [7:0] m_wdata, m_cpu_rdata, m_spr_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rst_n, input bit g, input logic [AW-1:0] ga,
                      input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [7:0] cd,
                      input bit sr, input logic [AW-1:0] sa, input bit chk);
    int who;  // 0 idle, 1 gfx, 2 cpu, 3 sprite
    bit starved, e_cv, e_sv, e_en, e_we, s_en, s_we;
    logic [AW-1:0] e_addr, s_addr;
    logic [7:0] e_din, s_din;
    @(negedge pxclk);
    reset_n = rst_n; gfx_rd_tick = g; gfx_addr = ga;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    spr_rd_req = sr; spr_addr = sa;
    #1;
    e_cv = 1'b0; e_sv = 1'b0;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].spr) begin e_sv = 1'b1; m_spr_rdata = rq[0].data; end
      else begin e_cv = 1'b1; m_cpu_rdata = rq[0].data; end
      rq.delete(0);
    end
    starved = SPR_EN && sr && (m_wait >= MAXW);
    if (g) who = 1;
    else if (starved) who = 3;
    else if (m_busy) who = 2;
    else if (SPR_EN && sr) who = 3;
    else who = 0;
    e_en   = (who != 0);
    e_we   = (who == 2) && m_we;
    e_addr = (who == 1) ? ga : (who == 2) ? m_addr : (who == 3) ? sa : '0;
    e_din  = e_we ? m_wdata : 8'h00;
    if (chk) begin
      check_eq("vram_en", vram_en, e_en);
      check_eq("vram_we", vram_we, e_we);
      check_eq("vram_addr", vram_addr, e_addr);
      if (e_we || !e_en) check_eq("vram_din", vram_din, e_din);
      check_eq("spr_rd_ack", spr_rd_ack, who == 3);
      check_eq("cpu_busy", cpu_busy, m_busy);
      check_eq("cpu_rd_valid", cpu_rd_valid, e_cv);
      check_eq("cpu_rdata", cpu_rdata, m_cpu_rdata);
      check_eq("spr_rd_valid", spr_rd_valid, e_sv);
      check_eq("spr_rdata", spr_rdata, m_spr_rdata);
`ifdef VDP_ARB_SPR_EN
      if (sr && spr_rd_ack) check_eq("spr_ack_latency_ok", spr_lost <= MAXW + 2, 1'b1);
`endif
    end
    s_en = vram_en; s_we = vram_we; s_addr = vram_addr; s_din = vram_din;
    @(posedge pxclk);
    if (chk && s_en && s_we) mem[s_addr] = s_din;
    if (who == 2 && m_we) exp_mem[m_addr] = m_wdata;
    if (!rst_n) begin
      m_busy = 1'b0; m_wait = 0; rq.delete(); spr_lost = 0;
      m_cpu_rdata = 8'h00; m_spr_rdata = 8'h00;
    end else begin
      if (who == 2 && !m_we) rq.push_back('{cyc + 2, 1'b0, exp_mem[m_addr]});
      if (who == 3) rq.push_back('{cyc + 2, 1'b1, exp_mem[sa]});
      if (who == 2) m_busy = 1'b0;
      else if (cr && !m_busy) begin m_busy = 1'b1; m_we = cw; m_addr = ca; m_wdata = cd; end
      if (SPR_EN && sr && who != 3) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
      else m_wait = 0;
      spr_lost = (sr && who != 3) ? spr_lost + 1 : 0;
    end
    m_spr_acked = (who == 3);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, '0, 0, 0, '0, 8'h00, 0, '0, 1);
  endtask

  initial begin
    bit g, pg, cr, cw, sr, rst;
    logic [AW-1:0] ga, ca, sa;
    logic [7:0] cd;
    checks = 0; failures = 0; cyc = 0; m_wait = 0; spr_lost = 0;
    m_busy = 0; m_we = 0; m_addr = '0; m_wdata = 8'h00; m_spr_acked = 0;
    m_cpu_rdata = 8'h00; m_spr_rdata = 8'h00;
    for (int i = 0; i < 8192; i++) begin mem[i] = 8'($urandom); exp_mem[i] = mem[i]; end
    mem[13'h0100] = 8'hC3; exp_mem[13'h0100] = 8'hC3;

    // Reset, then check reset state
    step(0, 0, '0, 0, 0, '0, 8'h00, 0, '0, 0);
    step(0, 0, '0, 0, 0, '0, 8'h00, 0, '0, 1);
    idle(1);

    // CPU write 0x5A to 0x1234, no gfx
    step(1, 0, '0, 1, 1, 13'h1234, 8'h5A, 0, '0, 1);
    idle(2);
    check_eq("wr_mem_1234", mem[13'h1234], 8'h5A);

    // CPU read of 0x0100 colliding with a gfx tick
    step(1, 0, '0, 1, 0, 13'h0100, 8'h00, 0, '0, 1);
    step(1, 1, 13'h0AAA, 0, 0, '0, 8'h00, 0, '0, 1);
    idle(4);
    check_eq("rd_0100_data", cpu_rdata, 8'hC3);

    // Second request while busy is dropped
    step(1, 0, '0, 1, 1, 13'h0222, 8'h11, 0, '0, 1);
    step(1, 1, 13'h0050, 1, 1, 13'h0333, 8'h22, 0, '0, 1);
    idle(3);

    // Reset the cycle after a CPU read grant
    step(1, 0, '0, 1, 0, 13'h0100, 8'h00, 0, '0, 1);
    idle(1);
    step(0, 0, '0, 0, 0, '0, 8'h00, 0, '0, 1);
    idle(3);

    // Random traffic: phase 0 sparse CPU, phase 1 back-to-back CPU with sprite held
    pg = 0; sr = 0; sa = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 2500; i++) begin
        g  = !pg && ($urandom_range(0, 2) == 0);
        ga = 13'($urandom);
        if (ph == 0) cr = ($urandom_range(0, 3) == 0);
        else cr = !m_busy || ($urandom_range(0, 3) == 0);
        cw = $urandom_range(0, 1);
        ca = 13'($urandom);
        cd = 8'($urandom);
        if (sr && m_spr_acked) begin
          sr = (ph == 1) ? 1'b1 : 1'($urandom_range(0, 1));
          sa = 13'($urandom);
        end else if (!sr) begin
          sr = (ph == 1) || ($urandom_range(0, 2) == 0);
          sa = 13'($urandom);
        end
        rst = ($urandom_range(0, 299) != 0);
        step(rst, g, ga, cr, cw, ca, cd, sr, sa, 1);
        pg = g;
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
